// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared definitions for the instruction encoder.
//   - enc_op_t     : abstract operation requested by the program source
//   - ERR_*        : error causes reported on err_code
//   - OPC_*/FN_*   : MIPS opcode / funct fields (same values the decode stage uses)
//   - r_word/i_word/j_word : field packers for the three MIPS formats
package instr_encoder_pkg;

    typedef enum logic [5:0] {
        ENC_NOP     = 6'd0,
        ENC_SLL     = 6'd1,
        ENC_SRL     = 6'd2,
        ENC_SRA     = 6'd3,
        ENC_SLLV    = 6'd4,
        ENC_SRLV    = 6'd5,
        ENC_SRAV    = 6'd6,
        ENC_JR      = 6'd7,
        ENC_SYSCALL = 6'd8,
        ENC_ADD     = 6'd9,
        ENC_ADDU    = 6'd10,
        ENC_SUB     = 6'd11,
        ENC_SUBU    = 6'd12,
        ENC_AND     = 6'd13,
        ENC_OR      = 6'd14,
        ENC_XOR     = 6'd15,
        ENC_NOR     = 6'd16,
        ENC_SLT     = 6'd17,
        ENC_SLTU    = 6'd18,
        ENC_BEQ     = 6'd19,
        ENC_BNE     = 6'd20,
        ENC_BLEZ    = 6'd21,
        ENC_BGTZ    = 6'd22,
        ENC_BLTZ    = 6'd23,
        ENC_BGEZ    = 6'd24,
        ENC_J       = 6'd25,
        ENC_JAL     = 6'd26,
        ENC_ADDI    = 6'd27,
        ENC_ADDIU   = 6'd28,
        ENC_SLTI    = 6'd29,
        ENC_SLTIU   = 6'd30,
        ENC_ANDI    = 6'd31,
        ENC_ORI     = 6'd32,
        ENC_XORI    = 6'd33,
        ENC_LUI     = 6'd34,
        ENC_LW      = 6'd35,
        ENC_SW      = 6'd36,
        ENC_LI      = 6'd37
    } enc_op_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_OP   = 3'd1;
    localparam logic [2:0] ERR_SIMM     = 3'd2;
    localparam logic [2:0] ERR_ZIMM     = 3'd3;
    localparam logic [2:0] ERR_JUMP     = 3'd4;
    localparam logic [2:0] ERR_LI_SPACE = 3'd5;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_REGIMM  = 6'h01;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_BLEZ    = 6'h06;
    localparam logic [5:0] OPC_BGTZ    = 6'h07;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // REGIMM branches are distinguished by the rt field
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRITE2, S_FULL} enc_state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OPC_SPECIAL, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/instr_encoder_word.sv
// mips_word_encoder: combinational packer from an abstract request to MIPS words.
//   op/rs/rt/rd/shamt/imm : request fields
//   word1, word2          : first word, optional second word (li only)
//   two_words             : word2 is valid
//   err_code              : ERR_NONE or the range/op error for this request
module mips_word_encoder
    import instr_encoder_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    output logic [31:0] word1,
    output logic [31:0] word2,
    output logic        two_words,
    output logic [2:0]  err_code
);
    logic        simm_ok;
    logic        zimm_ok;
    logic        jimm_ok;
    logic [15:0] imm16;
    logic [15:0] imm_hi;

    assign imm16   = imm[15:0];
    assign imm_hi  = imm[31:16];
    assign simm_ok = (imm_hi == {16{imm[15]}});
    assign zimm_ok = (imm_hi == 16'd0);
    assign jimm_ok = (imm[31:26] == 6'd0);

    always_comb begin
        word1     = '0;
        word2     = '0;
        two_words = 1'b0;
        err_code  = ERR_NONE;
        case (op)
            ENC_NOP:     word1 = '0;
            ENC_SLL:     word1 = r_word(5'd0, rt, rd, shamt, FN_SLL);
            ENC_SRL:     word1 = r_word(5'd0, rt, rd, shamt, FN_SRL);
            ENC_SRA:     word1 = r_word(5'd0, rt, rd, shamt, FN_SRA);
            // variable shifts carry the amount register in rs
            ENC_SLLV:    word1 = r_word(rs, rt, rd, 5'd0, FN_SLLV);
            ENC_SRLV:    word1 = r_word(rs, rt, rd, 5'd0, FN_SRLV);
            ENC_SRAV:    word1 = r_word(rs, rt, rd, 5'd0, FN_SRAV);
            ENC_JR:      word1 = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            ENC_SYSCALL: word1 = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
            ENC_ADD:     word1 = r_word(rs, rt, rd, 5'd0, FN_ADD);
            ENC_ADDU:    word1 = r_word(rs, rt, rd, 5'd0, FN_ADDU);
            ENC_SUB:     word1 = r_word(rs, rt, rd, 5'd0, FN_SUB);
            ENC_SUBU:    word1 = r_word(rs, rt, rd, 5'd0, FN_SUBU);
            ENC_AND:     word1 = r_word(rs, rt, rd, 5'd0, FN_AND);
            ENC_OR:      word1 = r_word(rs, rt, rd, 5'd0, FN_OR);
            ENC_XOR:     word1 = r_word(rs, rt, rd, 5'd0, FN_XOR);
            ENC_NOR:     word1 = r_word(rs, rt, rd, 5'd0, FN_NOR);
            ENC_SLT:     word1 = r_word(rs, rt, rd, 5'd0, FN_SLT);
            ENC_SLTU:    word1 = r_word(rs, rt, rd, 5'd0, FN_SLTU);
            ENC_BEQ:     word1 = i_word(OPC_BEQ, rs, rt, imm16);
            ENC_BNE:     word1 = i_word(OPC_BNE, rs, rt, imm16);
            ENC_BLEZ:    word1 = i_word(OPC_BLEZ, rs, 5'd0, imm16);
            ENC_BGTZ:    word1 = i_word(OPC_BGTZ, rs, 5'd0, imm16);
            ENC_BLTZ:    word1 = i_word(OPC_REGIMM, rs, RT_BLTZ, imm16);
            ENC_BGEZ:    word1 = i_word(OPC_REGIMM, rs, RT_BGEZ, imm16);
            ENC_J:       word1 = j_word(OPC_J, imm[25:0]);
            ENC_JAL:     word1 = j_word(OPC_JAL, imm[25:0]);
            ENC_ADDI:    word1 = i_word(OPC_ADDI, rs, rt, imm16);
            ENC_ADDIU:   word1 = i_word(OPC_ADDIU, rs, rt, imm16);
            ENC_SLTI:    word1 = i_word(OPC_SLTI, rs, rt, imm16);
            ENC_SLTIU:   word1 = i_word(OPC_SLTIU, rs, rt, imm16);
            ENC_ANDI:    word1 = i_word(OPC_ANDI, rs, rt, imm16);
            ENC_ORI:     word1 = i_word(OPC_ORI, rs, rt, imm16);
            ENC_XORI:    word1 = i_word(OPC_XORI, rs, rt, imm16);
            ENC_LUI:     word1 = i_word(OPC_LUI, 5'd0, rt, imm16);
            ENC_LW:      word1 = i_word(OPC_LW, rs, rt, imm16);
            ENC_SW:      word1 = i_word(OPC_SW, rs, rt, imm16);
            ENC_LI: begin
                // pick the shortest sequence that materialises the constant
                if (zimm_ok) begin
                    word1 = i_word(OPC_ORI, 5'd0, rt, imm16);
                end else if (imm16 == 16'd0) begin
                    word1 = i_word(OPC_LUI, 5'd0, rt, imm_hi);
                end else begin
                    word1     = i_word(OPC_LUI, 5'd0, rt, imm_hi);
                    word2     = i_word(OPC_ORI, rt, rt, imm16);
                    two_words = 1'b1;
                end
            end
            default:     err_code = ERR_BAD_OP;
        endcase

        case (op)
            ENC_BEQ, ENC_BNE, ENC_BLEZ, ENC_BGTZ, ENC_BLTZ, ENC_BGEZ,
            ENC_ADDI, ENC_ADDIU, ENC_SLTI, ENC_SLTIU, ENC_LW, ENC_SW:
                if (!simm_ok) err_code = ERR_SIMM;
            ENC_ANDI, ENC_ORI, ENC_XORI, ENC_LUI:
                if (!zimm_ok) err_code = ERR_ZIMM;
            ENC_J, ENC_JAL:
                if (!jimm_ok) err_code = ERR_JUMP;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts abstract instruction requests, encodes them and writes
// the resulting words sequentially into instruction memory.
//   clk, reset (sync, active-low)
//   in_valid/in_ready + in_op/in_rs/in_rt/in_rd/in_shamt/in_imm : request
//   mem_we/mem_addr/mem_wdata/mem_ready : memory write port (held until ready)
//   count : words written since reset; full : top address written
//   err/err_code : sticky error flag and first error cause
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [2:0]        err_code
);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word2_q, word2_d;
    logic              pend2_q, pend2_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              in_ready_q, in_ready_d;

    logic [31:0] enc_w1, enc_w2;
    logic        enc_two;
    logic [2:0]  enc_err;
    logic [2:0]  rej_code;

    mips_word_encoder u_enc (
        .op        (in_op),
        .rs        (in_rs),
        .rt        (in_rt),
        .rd        (in_rd),
        .shamt     (in_shamt),
        .imm       (in_imm),
        .word1     (enc_w1),
        .word2     (enc_w2),
        .two_words (enc_two),
        .err_code  (enc_err)
    );

    // a two-word li cannot start in the last slot: the address never wraps
    always_comb begin
        rej_code = enc_err;
        if (enc_err == ERR_NONE && enc_two && addr_q == TOP_ADDR) rej_code = ERR_LI_SPACE;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        word2_d    = word2_q;
        pend2_d    = pend2_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (rej_code != ERR_NONE) begin
                        // request is consumed; only the first cause is kept
                        err_d = 1'b1;
                        if (!err_q) err_code_d = rej_code;
                    end else begin
                        wdata_d = enc_w1;
                        word2_d = enc_w2;
                        pend2_d = enc_two;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE, S_WRITE2: begin
                if (mem_ready) begin
                    count_d = count_q + CNT_ONE;
                    if (addr_q == TOP_ADDR) begin
                        state_d = S_FULL;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                        if (pend2_q) begin
                            pend2_d = 1'b0;
                            wdata_d = word2_q;
                            state_d = S_WRITE2;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE;
            count_q    <= '0;
            wdata_q    <= '0;
            word2_q    <= '0;
            pend2_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            word2_q    <= word2_d;
            pend2_q    <= pend2_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = (state_q == S_WRITE) || (state_q == S_WRITE2);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign full      = (state_q == S_FULL);
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized requests,
// compared each cycle against a behavioural model (expected-write queue).
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int AW  = 3;
    localparam int CAP = 1 << AW;

    logic          clk = 0;
    logic          reset = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [5:0]    in_op = 0;
    logic [4:0]    in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
    logic [31:0]   in_imm = 0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [AW:0]   count;
    logic          full;
    logic          err;
    logic [2:0]    err_code;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .count(count), .full(full),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t q[$];
    int  mcount = 0;
    bit  merr = 0;
    int  mcode = 0;
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 0;
    bit  rdy_rand = 0;
    bit  rdy_fix = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rw(input int s, input int t, input int d, input int a, input int f);
        return (s << 21) | (t << 16) | (d << 11) | (a << 6) | f;
    endfunction

    function automatic logic [31:0] iw(input int o, input int s, input int t, input logic [31:0] i);
        return (o << 26) | (s << 21) | (t << 16) | (i & 32'h0000FFFF);
    endfunction

    function automatic void ref_encode(input logic [5:0] op, input int rs, input int rt,
                                       input int rd, input int sh, input logic [31:0] k,
                                       output logic [31:0] w1, output logic [31:0] w2,
                                       output bit two, output int code);
        int  cls;  // 1 signed-16, 2 zero-16, 3 jump target
        bit  sok, zok, jok;
        sok = ($signed(k) >= -32768) && ($signed(k) <= 32767);
        zok = (k < 32'h10000);
        jok = (k < 32'h4000000);
        w1 = 0; w2 = 0; two = 0; code = 0; cls = 0;
        case (op)
            ENC_NOP:     w1 = 0;
            ENC_SLL:     w1 = rw(0, rt, rd, sh, 'h00);
            ENC_SRL:     w1 = rw(0, rt, rd, sh, 'h02);
            ENC_SRA:     w1 = rw(0, rt, rd, sh, 'h03);
            ENC_SLLV:    w1 = rw(rs, rt, rd, 0, 'h04);
            ENC_SRLV:    w1 = rw(rs, rt, rd, 0, 'h06);
            ENC_SRAV:    w1 = rw(rs, rt, rd, 0, 'h07);
            ENC_JR:      w1 = rw(rs, 0, 0, 0, 'h08);
            ENC_SYSCALL: w1 = 32'h0000000C;
            ENC_ADD:     w1 = rw(rs, rt, rd, 0, 'h20);
            ENC_ADDU:    w1 = rw(rs, rt, rd, 0, 'h21);
            ENC_SUB:     w1 = rw(rs, rt, rd, 0, 'h22);
            ENC_SUBU:    w1 = rw(rs, rt, rd, 0, 'h23);
            ENC_AND:     w1 = rw(rs, rt, rd, 0, 'h24);
            ENC_OR:      w1 = rw(rs, rt, rd, 0, 'h25);
            ENC_XOR:     w1 = rw(rs, rt, rd, 0, 'h26);
            ENC_NOR:     w1 = rw(rs, rt, rd, 0, 'h27);
            ENC_SLT:     w1 = rw(rs, rt, rd, 0, 'h2A);
            ENC_SLTU:    w1 = rw(rs, rt, rd, 0, 'h2B);
            ENC_BEQ:     begin w1 = iw('h04, rs, rt, k); cls = 1; end
            ENC_BNE:     begin w1 = iw('h05, rs, rt, k); cls = 1; end
            ENC_BLEZ:    begin w1 = iw('h06, rs, 0, k); cls = 1; end
            ENC_BGTZ:    begin w1 = iw('h07, rs, 0, k); cls = 1; end
            ENC_BLTZ:    begin w1 = iw('h01, rs, 0, k); cls = 1; end
            ENC_BGEZ:    begin w1 = iw('h01, rs, 1, k); cls = 1; end
            ENC_J:       begin w1 = (32'h2 << 26) | (k & 32'h03FFFFFF); cls = 3; end
            ENC_JAL:     begin w1 = (32'h3 << 26) | (k & 32'h03FFFFFF); cls = 3; end
            ENC_ADDI:    begin w1 = iw('h08, rs, rt, k); cls = 1; end
            ENC_ADDIU:   begin w1 = iw('h09, rs, rt, k); cls = 1; end
            ENC_SLTI:    begin w1 = iw('h0A, rs, rt, k); cls = 1; end
            ENC_SLTIU:   begin w1 = iw('h0B, rs, rt, k); cls = 1; end
            ENC_ANDI:    begin w1 = iw('h0C, rs, rt, k); cls = 2; end
            ENC_ORI:     begin w1 = iw('h0D, rs, rt, k); cls = 2; end
            ENC_XORI:    begin w1 = iw('h0E, rs, rt, k); cls = 2; end
            ENC_LUI:     begin w1 = iw('h0F, 0, rt, k); cls = 2; end
            ENC_LW:      begin w1 = iw('h23, rs, rt, k); cls = 1; end
            ENC_SW:      begin w1 = iw('h2B, rs, rt, k); cls = 1; end
            ENC_LI: begin
                if (k < 32'h10000) w1 = iw('h0D, 0, rt, k);
                else if (k % 32'h10000 == 0) w1 = iw('h0F, 0, rt, k >> 16);
                else begin
                    w1 = iw('h0F, 0, rt, k >> 16);
                    w2 = iw('h0D, rt, rt, k);
                    two = 1;
                end
            end
            default: code = 1;
        endcase
        if (cls == 1 && !sok) code = 2;
        if (cls == 2 && !zok) code = 3;
        if (cls == 3 && !jok) code = 4;
    endfunction

    // ---------------- mem_ready driver ----------------
    initial begin
        mem_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(mcount));
            chk("full", 32'(full), 32'(mcount == CAP));
            chk("err", 32'(err), 32'(merr));
            chk("err_code", 32'(err_code), 32'(mcode));
            if (full) chk("full_ready", 32'(in_ready), 0);
            if (mem_we) begin
                chk("busy_ready", 32'(in_ready), 0);
                chk("write_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("mem_addr", 32'(mem_addr), 32'(q[0].a));
                    chk("mem_wdata", mem_wdata, q[0].d);
                    if (mem_ready) begin
                        void'(q.pop_front());
                        mcount++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        chk_en = 0; in_valid = 0; rdy_rand = 0; rdy_fix = 1; reset = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        q.delete(); mcount = 0; merr = 0; mcode = 0;
        reset = 1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(in_ready), 1);
        chk_en = 1;
    endtask

    task automatic send(input logic [5:0] op, input int rs, input int rt, input int rd,
                        input int sh, input logic [31:0] k);
        logic [31:0] w1, w2;
        bit  two;
        int  code, pos, n;
        wr_t e;
        ref_encode(op, rs, rt, rd, sh, k, w1, w2, two, code);
        pos = mcount + q.size();
        if (pos >= CAP) return;
        if (code == 0 && two && pos == CAP - 1) code = 5;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 32'(in_ready), 1);
            return;
        end
        in_valid = 1; in_op = op; in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = k;
        @(posedge clk);
        #1;
        in_valid = 0;
        if (code != 0) begin
            if (!merr) mcode = code;
            merr = 1;
        end else begin
            e.a = AW'(pos); e.d = w1; q.push_back(e);
            if (two) begin e.a = AW'(pos + 1); e.d = w2; q.push_back(e); end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] w1, w2, ha, hd;
        bit two;
        int code;

        // pin the model to hand-encoded words
        ref_encode(ENC_ADDU, 1, 2, 3, 0, 0, w1, w2, two, code);
        chk("model_addu", w1, 32'h00221821);
        ref_encode(ENC_LI, 0, 5, 0, 0, 32'h12345678, w1, w2, two, code);
        chk("model_li_hi", w1, 32'h3C051234);
        chk("model_li_lo", w2, 32'h34A55678);
        ref_encode(ENC_LI, 0, 4, 0, 0, 32'h1234, w1, w2, two, code);
        chk("model_li_short", w1, 32'h34041234);
        chk("model_li_two", 32'(two), 0);
        ref_encode(ENC_SLL, 0, 1, 2, 4, 0, w1, w2, two, code);
        chk("model_sll", w1, 32'h00011100);
        ref_encode(ENC_BGEZ, 3, 0, 0, 0, 32'hFFFFFFFF, w1, w2, two, code);
        chk("model_bgez", w1, 32'h0461FFFF);
        ref_encode(ENC_JAL, 0, 0, 0, 0, 32'h100, w1, w2, two, code);
        chk("model_jal", w1, 32'h0C000100);
        ref_encode(ENC_BEQ, 1, 2, 0, 0, 32'h00010000, w1, w2, two, code);
        chk("model_beq_err", 32'(code), 2);

        // directed program filling all 8 slots
        do_reset();
        send(ENC_ADDU, 1, 2, 3, 0, 0);
        drain();
        chk("addu_count", 32'(count), 1);
        send(ENC_LI, 0, 5, 0, 0, 32'h12345678);
        send(ENC_LI, 0, 4, 0, 0, 32'h1234);
        send(ENC_SLL, 0, 1, 2, 4, 0);
        send(ENC_BGEZ, 3, 0, 0, 0, 32'hFFFFFFFF);
        send(ENC_JAL, 0, 0, 0, 0, 32'h100);
        send(ENC_SYSCALL, 0, 0, 0, 0, 0);
        drain();
        @(negedge clk);
        chk("full_lit", 32'(full), 1);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), 8);

        // error is sticky and keeps the first cause
        do_reset();
        send(ENC_BEQ, 1, 2, 0, 0, 32'h00010000);
        send(ENC_ORI, 1, 2, 0, 0, 32'h00010000);
        send(ENC_ADDU, 1, 2, 3, 0, 0);
        drain();
        chk("err_lit", 32'(err), 1);
        chk("err_code_lit", 32'(err_code), 2);
        chk("err_then_write", 32'(count), 1);

        // back-pressure: hold mem_ready low for 5 cycles
        do_reset();
        rdy_fix = 0;
        repeat (2) @(posedge clk);
        #1;
        send(ENC_SLL, 0, 1, 2, 4, 0);
        @(negedge clk);
        ha = 32'(mem_addr); hd = mem_wdata;
        repeat (5) @(negedge clk);
        chk("hold_we", 32'(mem_we), 1);
        chk("hold_ready", 32'(in_ready), 0);
        chk("hold_addr", 32'(mem_addr), ha);
        chk("hold_data", mem_wdata, hd);
        chk("hold_count", 32'(count), 0);
        rdy_fix = 1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_one_write", 32'(count), 1);

        // two-word li with exactly one free slot
        do_reset();
        for (int i = 0; i < CAP - 1; i++) send(ENC_NOP, 0, 0, 0, 0, 0);
        send(ENC_LI, 0, 5, 0, 0, 32'h12345678);
        drain();
        chk("li_space_code", 32'(err_code), 5);
        chk("li_space_count", 32'(count), CAP - 1);
        send(ENC_NOP, 0, 0, 0, 0, 0);
        drain();

        // reset in the middle of a stalled write
        do_reset();
        rdy_fix = 0;
        repeat (2) @(posedge clk);
        #1;
        send(ENC_ADDU, 1, 2, 3, 0, 0);
        repeat (2) @(posedge clk);
        do_reset();

        // randomized requests
        for (int it = 0; it < 40; it++) begin
            do_reset();
            rdy_rand = (it % 2 == 1);
            for (int k = 0; k < 12; k++) begin
                logic [5:0]  op;
                logic [31:0] r, imm;
                int sel;
                if (mcount + q.size() >= CAP) break;
                op  = 6'($urandom_range(0, 40));
                r   = $urandom;
                sel = $urandom_range(0, 4);
                case (sel)
                    0: imm = {{16{r[15]}}, r[15:0]};
                    1: imm = r & 32'h0000FFFF;
                    2: imm = r;
                    3: imm = r & 32'h03FFFFFF;
                    default: imm = r & 32'hFFFF0000;
                endcase
                send(op, $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), imm);
            end
            drain();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Hardware assembler that turns abstract instruction requests (operation enum plus register/immediate fields) into 32-bit MIPS words and writes them sequentially into instruction memory. It supports every instruction the decode stage executes, plus the `li` and `nop` pseudo-ops. It sits between a test/boot program source and the instruction-memory write port, and is used to preload programs before the core leaves reset.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `BASE_ADDR`, default 0: first word address written after reset.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept a request.
- `in_op`  in  6  operation enum (package `ENC_*`).
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  instruction fields.
- `in_imm`  in  32  immediate, branch offset (words), jump field, or `li` constant.
- `mem_we`  out  1  write request.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  encoded word.
- `mem_ready`  in  1  write accepted this cycle.
- `count`  out  ADDR_W+1  words written since reset.
- `full`  out  1  capacity exhausted.
- `err`  out  1  sticky error flag.
- `err_code`  out  3  first error cause.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - WRITE: holds word 1.
  - WRITE2: holds the `li` low word.
  - FULL: `in_ready`=0 until reset.
- Handshake and field mapping:
  - Accept on `in_valid & in_ready`. All fields are registered; the word is packed in the same cycle; go to WRITE.
  - R-type: shifts use rt as source and rd as destination; `sllv/srlv/srav` place the shift amount in rs.
  - `bltz`: rt field = 0. `bgez`: rt field = 1. `blez/bgtz`: rt field = 0.
  - `j/jal`: field = `in_imm[25:0]`.
- `li rt, K`:
  - K[31:16]==0: one word, `ori rt,$0,K`.
  - Else K[15:0]==0: one word, `lui rt,K[31:16]`.
  - Else two words: `lui rt,K[31:16]`, then `ori rt,rt,K[15:0]`.
- `nop` encodes as 0x00000000.
- WRITE/WRITE2 behaviour:
  - `mem_we`=1 and address/data are held stable until `mem_ready`.
  - On `mem_ready`, address and `count` increment.
  - Next state: WRITE2 if a second word is pending; FULL if the last address was written; else IDLE.
- Range checks. A failing request is consumed and produces no write. It sets `err`; `err_code` keeps the first cause:
  - `1` = bad op.
  - `2` = signed-16 immediate (`addi/addiu/slti/sltiu/lw/sw`/branches) not equal to the sign-extension of `in_imm[15:0]`.
  - `3` = zero-extended immediate (`ori/xori/andi/lui`) with `in_imm[31:16]`≠0.
  - `4` = jump with `in_imm[31:26]`≠0.
  - `5` = two-word `li` with exactly one free slot.
- Address never wraps. Once the top word is written, the block enters FULL and `full`=1.

## Timing
- Reset values: `in_ready`=0 while reset is asserted, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `count`=0, `full`=0, `err`=0, `err_code`=0. State returns to IDLE.
- `in_ready`=1 in the first cycle after reset deasserts.
- Latency: request accepted at edge N drives `mem_we` in cycle N+1.
- With `mem_ready` tied high: the word is written at edge N+1 and IDLE resumes; peak throughput is 1 instruction per 2 cycles. A two-word `li` takes 3 cycles.
- An errored request returns to IDLE at the next edge with no `mem_we` pulse.
- Reset mid-write aborts the word (no partial state). `count` and `mem_addr` restart.
- `in_ready` is a registered function of state only. It never depends on `in_valid`.

## Structure
- Shared package holds:
  - the `ENC_*` op enum (38 values, 6 bits);
  - the `ERR_*` codes;
  - the MIPS opcode/funct constants, shared with the decode stage's definitions so both ends agree.
- Sub-module `mips_word_encoder`: purely combinational. Inputs are op plus fields. Outputs are word 1, word 2, `two_words`, and `err_code`.
- The top level holds the FSM, counters, and output registers.

## Test plan
- `addu rd=3,rs=1,rt=2` with `mem_ready`=1 → one write at address 0 of 0x00221821; `count`=1.
- `li rt=5, 0x12345678` → writes 0x3C051234 at address 0, then 0x34A55678 at address 1. `li rt=4, 0x1234` → single write 0x34041234.
- `sll rd=2,rt=1,shamt=4` → 0x00011100; `bgez rs=3, -1` → 0x0461FFFF; `jal 0x100` → 0x0C000100; `syscall` → 0x0000000C.
- `beq rs=1,rt=2, imm=0x00010000` → no write, `err`=1, `err_code`=2. A following valid request is still encoded, and `err_code` remains 2.
- Hold `mem_ready`=0 for 5 cycles during a write → address and data stable, `in_ready`=0. Reassert `mem_ready` → exactly one write.
- ADDR_W=2: four `nop` → `full`=1, `in_ready`=0. For the two-word case, issue three `nop`, then a two-word `li` → `err_code`=5, no write. Assert reset mid-write → all outputs return to their reset values.
